// File: rtl/cpu_cen_scheduler.sv
// cpu_cen_scheduler
//   Multi-channel CPU clock-enable scheduler. Each channel turns a base-rate
//   strobe (2x CPU clock) into alternating ce_2/ce_1 pulses for one CPU core.
//   Base strobes that arrive while the ROM cache is not ready are lost to the
//   CPU and recorded as stall debt. The debt is later repaid as rate-limited
//   catch-up pulses, so the long-run CPU speed matches the base rate.
//   A global pause, aligned to vsync, freezes all channels.
//
// Ports
//   clk_sys              : system clock (the only clock)
//   reset                : synchronous, active-high
//   base_ce   [CH]       : per-channel base strobe
//   ready     [CH]       : per-channel memory ready
//   turbo     [CH]       : per-channel advance-every-cycle mode
//   pause_rq, vsync      : pause request and frame sync for pause alignment
//   ovf_clr              : clears the sticky debt overflow flags
//   paused               : global pause state
//   ce_1, ce_2 [CH]      : registered raw phase strobes (to ROM cache)
//   ce_1_cpu, ce_2_cpu   : raw strobes gated by current ready (to CPU)
//   debt      [CH*DW]    : stall debt, channel i at [i*DEBT_W +: DEBT_W]
//   debt_ovf  [CH]       : sticky, set by an increment attempted at DEBT_LIMIT
//   cycle_cnt [CH*CW]    : wrapping count of ce_1_cpu pulses per channel

// Per-channel phase generator, debt accounting and catch-up pacing.
module cpu_cen_lane #(
    parameter int          DEBT_W      = 16,
    parameter int unsigned DEBT_LIMIT  = 16'hFFFF,
    parameter int          CATCHUP_GAP = 0,
    parameter int          CNT_W       = 16
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              paused,
    input  logic              base_ce,
    input  logic              ready,
    input  logic              turbo,
    input  logic              ovf_clr,
    output logic              ce_1,
    output logic              ce_2,
    output logic              ce_1_cpu,
    output logic              ce_2_cpu,
    output logic [DEBT_W-1:0] debt,
    output logic              debt_ovf,
    output logic [CNT_W-1:0]  cycle_cnt
);
    localparam int GAP_W = (CATCHUP_GAP > 0) ? $clog2(CATCHUP_GAP + 1) : 1;

    logic             toggle;
    logic [GAP_W-1:0] gap_cnt;
    logic             catch_ok, adv, catch_adv, stall, at_limit;

    always_comb begin
        catch_ok  = ready & (debt != '0) & (gap_cnt == '0);
        adv       = ~paused & (base_ce | turbo | catch_ok);
        // advance caused purely by catch-up repays one unit of debt
        catch_adv = adv & ~base_ce & ~turbo;
        // debt is frozen while paused, so a stall only counts when running
        stall     = ~paused & base_ce & ~ready;
        at_limit  = (debt == DEBT_W'(DEBT_LIMIT));
    end

    assign ce_1_cpu = ce_1 & ready;
    assign ce_2_cpu = ce_2 & ready;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            toggle    <= 1'b0;
            ce_1      <= 1'b0;
            ce_2      <= 1'b0;
            debt      <= '0;
            debt_ovf  <= 1'b0;
            gap_cnt   <= '0;
            cycle_cnt <= '0;
        end else begin
            // toggle=0 after reset, so the first advance yields ce_2
            ce_1 <= adv & toggle;
            ce_2 <= adv & ~toggle;
            if (adv)
                toggle <= ~toggle;

            // stall and catch_adv cannot coincide (catch_adv needs ~base_ce)
            if (stall) begin
                if (!at_limit)
                    debt <= debt + 1'b1;
            end else if (catch_adv) begin
                debt <= debt - 1'b1;
            end

            // a saturating increment wins over a coincident clear
            if (stall && at_limit)
                debt_ovf <= 1'b1;
            else if (ovf_clr)
                debt_ovf <= 1'b0;

            // with CATCHUP_GAP=0 this loads 0 and the counter never leaves 0
            if (catch_adv)
                gap_cnt <= GAP_W'(CATCHUP_GAP);
            else if (gap_cnt != '0)
                gap_cnt <= gap_cnt - 1'b1;

            if (ce_1_cpu)
                cycle_cnt <= cycle_cnt + 1'b1;
        end
    end
endmodule

module cpu_cen_scheduler #(
    parameter int          CHANNELS    = 2,
    parameter int          DEBT_W      = 16,
    parameter int unsigned DEBT_LIMIT  = 16'hFFFF,
    parameter int          CATCHUP_GAP = 0,
    parameter int          CNT_W       = 16
) (
    input  logic                       clk_sys,
    input  logic                       reset,
    input  logic [CHANNELS-1:0]        base_ce,
    input  logic [CHANNELS-1:0]        ready,
    input  logic [CHANNELS-1:0]        turbo,
    input  logic                       pause_rq,
    input  logic                       vsync,
    input  logic                       ovf_clr,
    output logic                       paused,
    output logic [CHANNELS-1:0]        ce_1,
    output logic [CHANNELS-1:0]        ce_2,
    output logic [CHANNELS-1:0]        ce_1_cpu,
    output logic [CHANNELS-1:0]        ce_2_cpu,
    output logic [CHANNELS*DEBT_W-1:0] debt,
    output logic [CHANNELS-1:0]        debt_ovf,
    output logic [CHANNELS*CNT_W-1:0]  cycle_cnt
);
    // Pause enters only on a vsync cycle and, once the request drops,
    // follows vsync so it exits on the first cycle vsync is low.
    always_ff @(posedge clk_sys) begin
        if (reset)
            paused <= 1'b0;
        else if (pause_rq & ~paused & vsync)
            paused <= 1'b1;
        else if (~pause_rq & paused)
            paused <= vsync;
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        cpu_cen_lane #(
            .DEBT_W      (DEBT_W),
            .DEBT_LIMIT  (DEBT_LIMIT),
            .CATCHUP_GAP (CATCHUP_GAP),
            .CNT_W       (CNT_W)
        ) u_lane (
            .clk_sys   (clk_sys),
            .reset     (reset),
            .paused    (paused),
            .base_ce   (base_ce[i]),
            .ready     (ready[i]),
            .turbo     (turbo[i]),
            .ovf_clr   (ovf_clr),
            .ce_1      (ce_1[i]),
            .ce_2      (ce_2[i]),
            .ce_1_cpu  (ce_1_cpu[i]),
            .ce_2_cpu  (ce_2_cpu[i]),
            .debt      (debt[i*DEBT_W +: DEBT_W]),
            .debt_ovf  (debt_ovf[i]),
            .cycle_cnt (cycle_cnt[i*CNT_W +: CNT_W])
        );
    end
endmodule

// File: doc/cpu_cen_scheduler.md
# cpu_cen_scheduler

Multi-channel CPU clock-enable scheduler with memory-stall debt accounting, frame-aligned pause, per-channel turbo and rate-limited catch-up. Each channel turns a base-rate strobe into two-phase `ce_1`/`ce_2` pulses for one CPU core, such as the main V33 or the sound Z80. Cycles lost while the ROM cache is not ready are recovered later as catch-up pulses, so long-run CPU speed matches the base rate. It sits between the fractional clock-enable generators and the CPU cores, ROM caches and cycle-timer logic in the board top level.

## Interface
Parameters:
- `CHANNELS`, 2, number of independent CPU channels.
- `DEBT_W`, 16, width of each stall-debt counter.
- `DEBT_LIMIT`, 16'hFFFF, saturation value for debt; must be ≤ 2^DEBT_W−1.
- `CATCHUP_GAP`, 0, minimum idle cycles between consecutive catch-up pulses; 0 means a pulse every cycle.
- `CNT_W`, 16, width of each per-channel CPU cycle counter.

Ports:
- `clk_sys` in 1: the only clock.
- `reset` in 1: synchronous, active-high.
- `base_ce` in CHANNELS: per-channel base strobe at twice the CPU clock (e.g. 18 MHz-derived).
- `ready` in CHANNELS: per-channel memory ready (ROM cache `rom_ready`).
- `turbo` in CHANNELS: per-channel advance-every-cycle mode.
- `pause_rq` in 1: pause request.
- `vsync` in 1: frame sync used for pause alignment.
- `ovf_clr` in 1: clears the sticky overflow flags.
- `paused` out 1: global pause state.
- `ce_1`, `ce_2` out CHANNELS: raw phase strobes, registered; these feed the ROM cache.
- `ce_1_cpu`, `ce_2_cpu` out CHANNELS: `ce_1 & ready` and `ce_2 & ready`, combinational from the registered strobe and current `ready`; these feed the CPU.
- `debt` out CHANNELS*DEBT_W: current debt, with channel i at bits [i*DEBT_W +: DEBT_W].
- `debt_ovf` out CHANNELS: sticky, set when an increment is attempted while debt == DEBT_LIMIT.
- `cycle_cnt` out CHANNELS*CNT_W: count of `ce_1_cpu` pulses per channel, wrapping.

## Operation
- **Pause (global):**
  - When `pause_rq & ~paused & vsync`, set `paused` to 1 next cycle.
  - When `~pause_rq & paused`, `paused` takes `vsync`. It therefore clears on the first cycle `vsync` is low.
  - `pause_rq` without `vsync` has no effect until `vsync` arrives.
- Per channel i, define:
  - `catch_ok` = `ready & (debt != 0) & gap_cnt == 0`.
  - `adv` = `~paused & (base_ce | turbo | catch_ok)`.
  - `catch` = `adv & ~base_ce & ~turbo` (the advance is caused purely by catch-up).
- **Phase:**
  - On `adv`, `toggle` flips; `ce_1` is set to the old `toggle` and `ce_2` to the old `~toggle`.
  - With no `adv`, both `ce_1` and `ce_2` are 0.
  - Exactly one of `ce_1`/`ce_2` pulses per advance, alternating and starting with `ce_2` after reset.
- **Debt** (held while `paused`):
  - `base_ce & ~ready`: increment, saturating at DEBT_LIMIT. Saturation sets `debt_ovf`.
  - `catch`: decrement by 1.
  - `base_ce & ready`: no change.
  - Increment and `catch` are mutually exclusive by construction.
  - `turbo` neither accrues nor drains debt except through `base_ce & ~ready`.
- **Gap counter:**
  - Loaded with CATCHUP_GAP on `catch`, otherwise decrements to 0.
  - It is unused (always 0) when CATCHUP_GAP = 0.
- **Cycle counter:** increments on `ce_1_cpu`, wraps modulo 2^CNT_W.
- **`ovf_clr`:** clears `debt_ovf`. If a saturating increment happens in the same cycle, the set wins.
- **Reset:** all outputs and internal state go to 0. This covers `paused`, `ce_*`, `toggle`, `debt`, `gap_cnt`, `cycle_cnt` and `debt_ovf`.

## Timing
- Latency: `base_ce`/`turbo`/`catch_ok` in cycle n produce `ce_1`/`ce_2` in cycle n+1. `debt` updates at n+1.
- `ce_1_cpu`/`ce_2_cpu` have zero latency from `ready`. A strobe with `ready` low is lost to the CPU; only `base_ce & ~ready` is counted as debt.
- Pause entry is 1 cycle after the qualifying `vsync` cycle; exit follows `vsync` low with 1-cycle latency.
- `adv` is blocked in the same cycle `paused` is 1. A pending `ce` already registered still appears once.
- Catch-up rate is at most one pulse per CATCHUP_GAP+1 cycles; drain continues until debt reaches 0.
- Reset asserted mid-catch-up drops all debt. The first cycle after reset release produces no strobe unless `adv` is true in that cycle.
- Channels are fully independent except for the shared `paused`.

## Test plan
- **Basic phase:** `base_ce` every 3rd cycle, `ready`=1, turbo=0, 12 cycles → 4 strobes, sequence ce_2, ce_1, ce_2, ce_1, each 1 cycle after its `base_ce`; debt stays 0; `cycle_cnt`=2.
- **Stall and catch-up:** CATCHUP_GAP=0, `ready`=0 across 5 `base_ce` → debt=5, `ce_*_cpu` silent. Then `ready`=1 with `base_ce` idle → 5 consecutive catch-up strobes, debt 5→0, then silence.
- **Gap limit:** CATCHUP_GAP=2, debt=3, `ready`=1, no `base_ce` → catch-up strobes at cycles 1, 4 and 7; debt reaches 0 after the third.
- **Saturation:** DEBT_W=4, DEBT_LIMIT=15, 17 stalled `base_ce` → debt=15 and `debt_ovf`=1. `ovf_clr` pulse → `debt_ovf`=0 with debt still 15. `ovf_clr` coincident with a saturating stall → `debt_ovf` stays 1.
- **Pause:** `pause_rq`=1 while `vsync`=0 → strobes continue. At `vsync`=1, `paused`=1 on the next cycle and strobes and debt freeze. Drop `pause_rq` while `vsync`=1 → still paused; `vsync`=0 → `paused`=0 on the next cycle.
- **Turbo and independence:** channel 0 turbo=1, channel 1 normal → ch0 strobes every cycle and `cycle_cnt0` advances by 1 every 2 cycles; ch1 is unaffected. Reset mid-run → all outputs 0 on the next cycle.
